cla_rr_arbiter: RTL
===================

Name: cla_rr_arbiter

Overview:
- Shares one 32-bit `cla` adder instance among NREQ independent requesters.
- Each requester issues add or subtract operations over a valid/ready handshake.
- A round-robin scheduler picks one request per cycle, configures the adder (operand inversion, carry-in) and registers the result with the requester ID.
- The result is presented on a single response channel that supports backpressure.
- Sits between ALU-side clients and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of rsp_id (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request i valid.
- req_ready  out  NREQ  request i accepted this cycle.
- req_a  in  NREQ*32  operand A, slice i = bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same slicing.
- req_cin  in  NREQ  carry-in for add; ignored for sub.
- req_sub  in  NREQ  1 = compute A-B, 0 = A+B+cin.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- rsp_sum  out  32  result.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0.
  - req_ready is all-zero while rst_n=0.
- Slot free: `free = !rsp_valid || rsp_ready`.
- Grant selection (combinational):
  - grant = first i with req_valid[i], scanning ptr, ptr+1, … mod NREQ.
  - req_ready is one-hot at grant when free and any req_valid is set; all-zero otherwise.
  - req_ready never depends on rsp_valid of the same cycle beyond the `free` term.
- Adder configuration for the granted slice:
  - cla.a = A.
  - sub=1: cla.b = ~B, cla.cin = 1.
  - sub=0: cla.b = B, cla.cin = req_cin.
  - Result is sum mod 2^32; no carry-out or flag.
- Accept (req_valid[g] && req_ready[g]):
  - Next edge: rsp_sum <= cla.sum, rsp_id <= g, rsp_valid <= 1, ptr <= (g+1) mod NREQ.
  - Latency is one cycle, request accept to rsp_valid.
- Drain without refill (rsp_valid && rsp_ready && no accept): rsp_valid <= 0; rsp_sum and rsp_id hold.
- Simultaneous drain and accept: the new result overwrites. Throughput is one op per cycle with no bubble.
- Backpressure (rsp_valid && !rsp_ready):
  - No grants; rsp_* hold stable; ptr holds.
  - Requesters must hold req_* stable while req_valid=1 and not ready.
- No request: ptr holds; no state change.
- Pointer wrap: g=NREQ-1 sets ptr to 0.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Reset mid-operation: any pending result is discarded; rsp_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: CLA_RR_ARBITER_OVF_EN.
- Defined:
  - Adds output port `rsp_ovf` (1 bit), registered with rsp_sum, reset 0.
  - rsp_ovf = signed two's-complement overflow of the performed operation.
  - It is computed from A[31], the effective B[31] (post-inversion) and sum[31]: the two operand MSBs are equal and sum[31] differs.
- Undefined: the port is absent and no overflow logic is generated.

Decomposition:
- Shared package `cla_arb_pkg`:
  - localparam DATA_W=32.
  - typedef `add_op_t` (enum 1-bit: OP_ADD=0, OP_SUB=1).
  - typedef `arb_rsp_t` struct {id, sum[, ovf]}.
- Sub-module `rr_pick`:
  - Pure combinational round-robin priority picker.
  - Inputs: req vector and ptr. Outputs: one-hot grant, encoded index, any.
  - Reusable by other shared-resource arbiters.
- The existing `cla` is instantiated once, unmodified.

Test Plan:
- Single op: req0 A=0x0000_0005, B=0x0000_0003, sub=0, cin=1, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x0000_0009.
- Subtract wrap: req2 A=0x0000_0000, B=0x0000_0001, sub=1 → rsp_sum=0xFFFF_FFFF, rsp_id=2.
  - With OVF_EN, A=0x8000_0000, B=1, sub=1 → rsp_ovf=1.
- Round-robin: all 4 req_valid held high, rsp_ready=1 → grant sequence 0,1,2,3,0 on consecutive cycles; rsp_valid continuously 1.
- Backpressure: rsp_ready=0 for 3 cycles with req1 and req3 pending → req_ready=0 throughout and rsp_* stable. On release, req1 is accepted on that same cycle; req3 is accepted one cycle later.
- Add overflow wrap: req1 A=0xFFFF_FFFF, B=0x0000_0001, sub=0, cin=0 → rsp_sum=0x0000_0000.
- Async reset: assert rst_n=0 mid-cycle while rsp_valid=1 → rsp_valid drops immediately. After release, the first grant goes to the lowest valid index from ptr=0.

Source files
------------

// File: rtl/cla_arb_pkg.sv
// cla_arb_pkg: shared types for the round-robin shared-adder arbiter.
// CLA_RR_ARBITER_OVF_EN adds a signed-overflow bit to the response record.
package cla_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W = 3;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] sum;
`ifdef CLA_RR_ARBITER_OVF_EN
    logic              ovf;
`endif
  } arb_rsp_t;
endpackage

// File: rtl/cla.sv
// cla: 32-bit carry-lookahead adder, 4-bit lookahead groups chained by group generate/propagate.
module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] p, g, c;
  assign p = a ^ b;
  assign g = a & b;
  always_comb begin
    logic bc;
    bc = cin;
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = bc;
      c[4*k+1] = g[4*k] | (p[4*k] & bc);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc);
      bc = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k +: 4]) & bc);
    end
  end
  assign sum = p ^ c;
endmodule

// File: rtl/cla_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Descending scan so the position nearest ptr_i is the last (winning) write.
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/cla_rr_arbiter.sv
// cla_rr_arbiter: NREQ requesters share one cla adder via round-robin, one registered response slot.
// CLA_RR_ARBITER_OVF_EN adds the rsp_ovf output (signed overflow of the granted operation).
module cla_rr_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  input  logic [NREQ-1:0]        req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_sum
`ifdef CLA_RR_ARBITER_OVF_EN
  ,output logic                  rsp_ovf
`endif
);
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    g, ptr_q, ptr_d;
  logic              any, free, accept, rsp_valid_q, rsp_valid_d, op_cin;
  logic [DATA_W-1:0] op_a, op_b, sum;
  add_op_t           op;
  arb_rsp_t          rsp_q, rsp_d;
  rr_pick #(.N(NREQ)) u_pick (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(g),
    .any_o(any)
  );
  always_comb begin
    op     = add_op_t'(req_sub[g]);
    op_a   = req_a[g*DATA_W +: DATA_W];
    op_b   = op == OP_SUB ? ~req_b[g*DATA_W +: DATA_W] : req_b[g*DATA_W +: DATA_W];
    op_cin = op == OP_SUB ? 1'b1 : req_cin[g];
  end
  cla u_cla (
    .a(op_a),
    .b(op_b),
    .cin(op_cin),
    .sum(sum)
  );
  assign free      = !rsp_valid_q || rsp_ready;
  assign accept    = rst_n && free && any;
  assign req_ready = accept ? gnt : '0;
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_d.id    = ID_W'(g);
      rsp_d.sum   = sum;
`ifdef CLA_RR_ARBITER_OVF_EN
      rsp_d.ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
`endif
      rsp_valid_d = 1'b1;
      ptr_d       = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      ptr_q       <= ptr_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = IDW'(rsp_q.id);
  assign rsp_sum   = rsp_q.sum;
`ifdef CLA_RR_ARBITER_OVF_EN
  assign rsp_ovf   = rsp_q.ovf;
`endif
endmodule
